// File: rtl/mips_mem_slave.sv
// mips_mem_slave: unified word memory with req/ready handshake, wait states and error flagging.
// Revision 1.0
`default_nettype none

module mips_mem_slave #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          DEPTH   = 1 << ADDR_W;
    localparam logic [3:0]  LAT     = 4'(LATENCY);
    localparam logic [31:0] POISON  = 32'hCCCC_CCCC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        enter_resp;

    logic [31:0] mem_q [DEPTH];

    logic              cur_we;
    logic [31:0]       cur_addr, cur_wdata;
    logic [3:0]        cur_be;
    logic [ADDR_W-1:0] cur_idx;
    logic              cur_bad;

    // With LATENCY=0 the accept edge is also the response edge, so the live inputs are used there.
    always_comb begin
        cur_we    = (state_q == IDLE) ? we    : we_q;
        cur_addr  = (state_q == IDLE) ? addr  : addr_q;
        cur_wdata = (state_q == IDLE) ? wdata : wdata_q;
        cur_be    = (state_q == IDLE) ? be    : be_q;
        cur_idx   = cur_addr[ADDR_W+1:2];
        cur_bad   = (cur_addr[1:0] != 2'b00) || (cur_addr[31:ADDR_W+2] != '0);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LAT == 4'd0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = 1'b0;
        if (enter_resp) begin
            err_d = cur_bad;
            if (cur_bad) begin
                rdata_d = POISON;
            end else if (!cur_we) begin
                rdata_d = mem_q[cur_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= POISON;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == IDLE && req) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                be_q    <= be;
            end
        end
    end

    // Array is not reset; rst_n gating keeps an edge seen during reset from committing a write.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && cur_we && !cur_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem_q[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ready = (state_q == RESP);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_slave.sv
// tb_mips_mem_slave: directed scoreboard bench for mips_mem_slave (LATENCY=2 and LATENCY=0 instances).
// Revision 1.0
`default_nettype none

module tb_mips_mem_slave;

    localparam int          LAT    = 2;
    localparam logic [31:0] POISON = 32'hCCCC_CCCC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        ready, err;
    logic [31:0] rdata;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [3:0]  be0 = '0;
    logic        ready0, err0;
    logic [31:0] rdata0;

    mips_mem_slave #(.ADDR_W(10), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .ready(ready), .rdata(rdata), .err(err)
    );

    mips_mem_slave #(.ADDR_W(10), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .be(be0), .ready(ready0), .rdata(rdata0), .err(err0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        er;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int];
    logic [31:0] last_rd = POISON;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t predict(input logic w, input logic [31:0] a, input logic [31:0] d,
                                     input logic [3:0] b);
        exp_t        e;
        int          idx;
        logic [31:0] word;
        idx  = int'(a[11:2]);
        e.er = (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
        if (e.er) begin
            e.rd = POISON;
        end else if (!w) begin
            e.rd = model.exists(idx) ? model[idx] : 32'hxxxx_xxxx;
        end else begin
            word = model.exists(idx) ? model[idx] : 32'd0;
            for (int i = 0; i < 4; i++)
                if (b[i]) word[8*i +: 8] = d[8*i +: 8];
            model[idx] = word;
            e.rd = last_rd;
        end
        return e;
    endfunction

    task automatic xact(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
        exp_t e;
        int   n;
        bit   seen;
        e = predict(w, a, d, b);
        sb.push_back(e);
        last_rd = e.rd;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            // Scramble the bus after acceptance: the DUT must use its latched copy.
            req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom; be = 4'($urandom);
            if (ready) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        e = sb.pop_front();
        if (seen) begin
            chk({tag, "_lat"}, 32'(n), 32'(LAT));
            chk({tag, "_rdata"}, rdata, e.rd);
            chk({tag, "_err"}, 32'(err), 32'(e.er));
            @(negedge clk);
            chk({tag, "_ready_drop"}, 32'(ready), 32'd0);
            chk({tag, "_err_low"}, 32'(err), 32'd0);
            chk({tag, "_rdata_hold"}, rdata, e.rd);
        end
    endtask

    initial begin
        exp_t e;
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, POISON);
        chk("rst0_ready", 32'(ready0), 32'd0);
        rst_n = 1'b1;

        xact("wr_0", 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF);
        xact("rd_0", 1'b0, 32'h0, 32'h0, 4'h0);
        xact("wr_10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        xact("rd_10", 1'b0, 32'h10, 32'h0, 4'h0);
        xact("wr_10_mask", 1'b1, 32'h10, 32'h1122_3344, 4'b0101);
        xact("rd_10_mask", 1'b0, 32'h10, 32'h0, 4'h0);
        xact("wr_10_noop", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000);
        xact("rd_10_noop", 1'b0, 32'h10, 32'h0, 4'h0);
        chk("model_mask", model[4], 32'hDE22_BE44);
        xact("rd_misalign", 1'b0, 32'h13, 32'h0, 4'h0);
        xact("wr_range", 1'b1, 32'h1000, 32'h0, 4'hF);
        xact("rd_0_after_err", 1'b0, 32'h0, 32'h0, 4'h0);
        xact("wr_20", 1'b1, 32'h20, 32'h1234_5678, 4'hF);

        // Abort a write to 0x20 during WAIT
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hA5A5_A5A5; be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_rdata", rdata, POISON);
        @(negedge clk);
        rst_n = 1'b1;
        last_rd = POISON;
        xact("rd_20_after_abort", 1'b0, 32'h20, 32'h0, 4'h0);

        // LATENCY=0 instance, req held for four edges: two complete writes
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h5555_AAAA; be0 = 4'hF;
        e.rd = POISON; e.er = 1'b0;
        sb.push_back(e);
        sb.push_back(e);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 3) req0 = 1'b0;
            chk($sformatf("hold_ready_%0d", k), 32'(ready0), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (ready0) begin
                if (sb.size() > 0) e = sb.pop_front();
                chk($sformatf("hold_err_%0d", k), 32'(err0), 32'(e.er));
                chk($sformatf("hold_rdata_%0d", k), rdata0, e.rd);
            end
        end
        chk("hold_sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        chk("hold_idle", 32'(ready0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_mem_slave.md
Name: mips_mem_slave

Overview:
- Unified instruction/data word memory. It sits on the responder side of the multi-cycle MIPS memory interface.
- It accepts one read or write request at a time from the CPU-side memory module over a req/ready handshake.
- It applies a programmable wait-state latency, then returns read data or commits byte-masked write data.
- Misaligned and out-of-range accesses are flagged instead of being silently aliased.

Parameters:
- ADDR_W, 10, number of word-address bits. The array holds 2^ADDR_W 32-bit words.
- LATENCY, 2, number of wait cycles between request acceptance and response. Legal range is 0..15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  request valid; held high by the requester until ready.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  32  byte address; word index is addr[ADDR_W+1:2].
- wdata  input  32  write data; sampled with req.
- be  input  4  byte enables; be[i] covers wdata[8i+7:8i]; writes only.
- ready  output  1  one-cycle response strobe.
- rdata  output  32  read data; valid while ready=1 for a read; held afterwards.
- err  output  1  error flag; valid only while ready=1.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=0, err=0, rdata=32'hCCCC_CCCC, wait counter=0.
  - Memory array contents are not reset.
  - Reset mid-operation aborts the transaction. A write that has not yet reached RESP is never committed.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on a rising edge with req=1, latch we, addr, wdata, be (accept edge E0).
    - LATENCY=0: go to RESP.
    - Otherwise: go to WAIT with counter=LATENCY.
  - WAIT: decrement counter each edge. At the edge where counter==1, go to RESP.
  - RESP: ready=1 for exactly one cycle, then unconditionally IDLE.
- Latency: ready is high in the cycle following edge E0+LATENCY.
  - LATENCY=0 gives ready one cycle after acceptance.
  - LATENCY=2 gives ready three cycles after acceptance.
- Input stability: req, we, addr, wdata and be are ignored outside IDLE. Latched copies are used, so requester changes mid-transaction have no effect.
- Back-to-back requests:
  - req still high during the RESP cycle belongs to the finished transaction.
  - A new request is sampled only in IDLE, so there is a minimum of one IDLE cycle between transactions.
  - A requester that keeps req high after ready gets a second, identical transaction.
- Error condition: err=1 if latched addr[1:0]!=0, or latched addr[31:ADDR_W+2]!=0.
  - On error: no memory write, rdata=32'hCCCC_CCCC, err=1 with ready.
- Read: rdata registered at the edge entering RESP with mem[word index]. It holds until the next response or reset.
- Write:
  - Committed at the edge entering RESP, per enabled byte only.
  - be=4'b0000 is a legal no-op write that still responds ready=1, err=0.
  - rdata is unchanged by writes.
- err is 0 in every cycle where ready=0.
- Counter width is 4 bits; no wrap is possible within the legal LATENCY range.

Test Plan:
- Reset/latency:
  - Stimulus: assert rst_n=0 and check outputs; release, LATENCY=2, read addr=0x0 written earlier.
  - Required response: during reset ready=0, err=0, rdata=32'hCCCC_CCCC. After release, ready is high exactly in cycle E0+3 (counting from the accept edge) for one cycle only.
- Full write then read:
  - Stimulus: write addr=0x10, wdata=32'hDEAD_BEEF, be=4'hF; then read addr=0x10.
  - Required response: read returns rdata=32'hDEAD_BEEF, err=0.
- Byte-masked write:
  - Stimulus: start with mem[0x10]=32'hDEAD_BEEF; write wdata=32'h1122_3344, be=4'b0101; then read 0x10.
  - Required response: rdata=32'hDE22_BE44.
- Errors:
  - Stimulus: read addr=0x13; then write addr=0x1000 (ADDR_W=10), wdata=32'h0, be=4'hF.
  - Required response: both return ready=1, err=1, rdata=32'hCCCC_CCCC. A later read of 0x0 is unchanged.
- Abort and hold-over:
  - Stimulus: start a write to 0x20 with wdata=32'hA5A5_A5A5; pulse rst_n=0 during WAIT; read 0x20 afterwards.
  - Required response: the read returns the old value, so the write is not committed.
  - Stimulus: with LATENCY=0, hold req high for 4 cycles.
  - Required response: ready pulses every other cycle, giving two complete transactions.
